writeback_commit_unit: RTL
==========================

WRITEBACK_COMMIT_UNIT -- requirements
Module: writeback_commit_unit

Interface
REQ-001 Parameter: DEPTH, 4, number of reorder entries; fixed at 4 because entries are indexed directly by the 2-bit pID.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-low reset.
REQ-003 Way 0 write-back inputs SHALL be:
- way0_valid_i  input  1  write-back present.
- way0_rdWriteEnable_i  input  1  instruction writes rd.
- way0_rdAddr_i  input  5  destination register.
- way0_rdData_i  input  64  result data.
- way0_pID_i  input  2  program-order ID.
- way0_ready_o  output  1  entry accept.
REQ-004 Way 1 SHALL have the same ports with prefix way1_.
REQ-005 Flush input SHALL be: flush_i  input  1  discard all uncommitted entries.
REQ-006 Register-file commit outputs SHALL be:
- rdWriteEnable_o  output  1  write strobe.
- rdAddr_o  output  5  destination register.
- rdData_o  output  64  data.
- commitValid_o  output  1  one entry retired.
- commitPID_o  output  2  ID retired.
- occupancy_o  output  3  occupied entries, 0..4.

Function
REQ-007 Entry[k] SHALL hold {occupied, we, addr[4:0], data[63:0]}.
REQ-008 wayN_ready_o SHALL be combinational and equal to !occupied[wayN_pID_i] && !flush_i.
REQ-009 If both ways are valid with equal pID, way0 SHALL win and way1_ready_o SHALL be 0.
REQ-010 A way SHALL be accepted on an edge where valid_i && ready_o; the edge writes its entry[pID] and sets occupied.
REQ-011 Stored we SHALL equal rdWriteEnable_i && valid_i.
REQ-012 commitPtr[1:0] SHALL reset to 0.
REQ-013 On each edge where occupied[commitPtr] is 1 and flush_i is 0, the block SHALL retire exactly that entry:
- clear occupied.
- commitPtr increments by 1, wrapping 3 -> 0.
- register outputs: commitValid_o=1, commitPID_o=commitPtr, rdWriteEnable_o=entry.we, rdAddr_o, rdData_o.
REQ-014 Otherwise commitValid_o and rdWriteEnable_o SHALL be 0 on the next cycle; rdAddr_o and rdData_o SHALL hold their previous values.
REQ-015 At most one entry SHALL retire per cycle, strictly in pID order; entries ahead of an empty commitPtr slot SHALL wait.
REQ-016 Latency: an entry accepted at edge E0, with commitPtr pointing to it, SHALL appear on the outputs after edge E1, i.e. 2 cycles from input to register-file strobe.
REQ-017 The slot being retired on an edge SHALL NOT be re-accepted on that same edge, because ready uses the pre-edge occupied value.
REQ-018 A new accept and a retire of different slots on the same edge SHALL both take effect.
REQ-019 occupancy_o SHALL equal the popcount of occupied; its value after each edge SHALL be the prior value + accepts − retires.
REQ-020 When flush_i=1, the edge SHALL:
- clear all occupied bits.
- set commitPtr=0.
- force commitValid_o=0 and rdWriteEnable_o=0.
- ignore inputs.
REQ-021 A retire with we=0 SHALL assert commitValid_o=1 with rdWriteEnable_o=0.
REQ-022 A retire SHALL NOT drive rdWriteEnable_o=1 when rdAddr_o=0; x0 writes are suppressed, while commitValid_o still pulses.

Reset
REQ-023 While rst=0 at an edge, the block SHALL clear all occupied bits and set commitPtr=0.
REQ-024 While rst=0 at an edge, the block SHALL set rdWriteEnable_o=0, rdAddr_o=0, rdData_o=0, commitValid_o=0, commitPID_o=0 and occupancy_o=0.
REQ-025 Reset asserted mid-operation SHALL discard buffered entries with no commit emitted on the following cycle.
REQ-026 Both ready outputs SHALL be 1 on the first cycle after reset release when flush_i=0.

Verification
REQ-027 Single write: way0 accepts {pID=0, rd=5, data=0xA5} -> two cycles later rdWriteEnable_o=1, rdAddr_o=5, rdData_o=0xA5, commitPID_o=0.
REQ-028 Out-of-order: way1 pID=1 (rd=3) in cycle 0, then way0 pID=0 (rd=2) in cycle 3 -> nothing retires before pID 0; rd2 then rd3 commit on consecutive cycles.
REQ-029 Conflict: both ways valid with pID=2 -> way0_ready_o=1 and way1_ready_o=0; only way0 data commits.
REQ-030 Full/wrap: fill pIDs 0..3 -> occupancy_o=4 and ready=0 for all pIDs; the block drains in order 0,1,2,3 and commitPtr returns to 0.
REQ-031 Flush with occupancy 3 -> next cycle occupancy_o=0, no commit strobes, and commitPtr=0.
REQ-032 x0 and no-write cases: accept rd=0 with we=1, and accept we=0 -> each yields commitValid_o=1 with rdWriteEnable_o=0.

Source files
------------

// File: rtl/writeback_commit_unit_if.sv
// Write-back / commit bundle for writeback_commit_unit: two write-back ways,
// flush, and the register-file commit port.
interface writeback_commit_unit_if;
  logic        way0_valid_i;
  logic        way0_rdWriteEnable_i;
  logic [4:0]  way0_rdAddr_i;
  logic [63:0] way0_rdData_i;
  logic [1:0]  way0_pID_i;
  logic        way0_ready_o;

  logic        way1_valid_i;
  logic        way1_rdWriteEnable_i;
  logic [4:0]  way1_rdAddr_i;
  logic [63:0] way1_rdData_i;
  logic [1:0]  way1_pID_i;
  logic        way1_ready_o;

  logic        flush_i;

  logic        rdWriteEnable_o;
  logic [4:0]  rdAddr_o;
  logic [63:0] rdData_o;
  logic        commitValid_o;
  logic [1:0]  commitPID_o;
  logic [2:0]  occupancy_o;

  modport master (
    output way0_valid_i, way0_rdWriteEnable_i, way0_rdAddr_i, way0_rdData_i, way0_pID_i,
    output way1_valid_i, way1_rdWriteEnable_i, way1_rdAddr_i, way1_rdData_i, way1_pID_i,
    output flush_i,
    input  way0_ready_o, way1_ready_o,
    input  rdWriteEnable_o, rdAddr_o, rdData_o, commitValid_o, commitPID_o, occupancy_o
  );

  modport slave (
    input  way0_valid_i, way0_rdWriteEnable_i, way0_rdAddr_i, way0_rdData_i, way0_pID_i,
    input  way1_valid_i, way1_rdWriteEnable_i, way1_rdAddr_i, way1_rdData_i, way1_pID_i,
    input  flush_i,
    output way0_ready_o, way1_ready_o,
    output rdWriteEnable_o, rdAddr_o, rdData_o, commitValid_o, commitPID_o, occupancy_o
  );
endinterface

// File: rtl/writeback_commit_unit.sv
// Four-entry reorder buffer indexed by pID: accepts two out-of-order write-backs
// per cycle and retires at most one entry per cycle, strictly in pID order.
module writeback_commit_unit #(
  parameter int unsigned DEPTH = 4
) (
  input logic                    clk,
  input logic                    rst,
  writeback_commit_unit_if.slave bus
);

  logic [DEPTH-1:0] occ_q, occ_d;
  logic [DEPTH-1:0] we_q;
  logic [4:0]       addr_q [DEPTH];
  logic [63:0]      data_q [DEPTH];
  logic [1:0]       ptr_q;

  logic             cvalid_q, cwe_q;
  logic [1:0]       cpid_q;
  logic [4:0]       caddr_q;
  logic [63:0]      cdata_q;

  logic             ready0, ready1, acc0, acc1, retire;
  logic [2:0]       occ_cnt;

  // Ready looks only at pre-edge occupancy, so a slot retiring this edge stays closed.
  always_comb begin
    ready0 = !occ_q[bus.way0_pID_i] && !bus.flush_i;
    ready1 = !occ_q[bus.way1_pID_i] && !bus.flush_i
             && !(bus.way0_valid_i && (bus.way0_pID_i == bus.way1_pID_i));
    acc0   = bus.way0_valid_i && ready0;
    acc1   = bus.way1_valid_i && ready1;
    retire = occ_q[ptr_q] && !bus.flush_i;
  end

  always_comb begin
    occ_d = occ_q;
    if (retire) occ_d[ptr_q] = 1'b0;
    if (acc0)   occ_d[bus.way0_pID_i] = 1'b1;
    if (acc1)   occ_d[bus.way1_pID_i] = 1'b1;
    if (bus.flush_i) occ_d = '0;
  end

  always_comb begin
    occ_cnt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occ_cnt = occ_cnt + 3'(occ_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      occ_q    <= '0;
      ptr_q    <= '0;
      cvalid_q <= 1'b0;
      cwe_q    <= 1'b0;
      cpid_q   <= '0;
      caddr_q  <= '0;
      cdata_q  <= '0;
    end else begin
      occ_q <= occ_d;
      if (bus.flush_i) begin
        ptr_q    <= '0;
        cvalid_q <= 1'b0;
        cwe_q    <= 1'b0;
      end else if (retire) begin
        ptr_q    <= ptr_q + 2'd1;
        cvalid_q <= 1'b1;
        cpid_q   <= ptr_q;
        // x0 is hard-wired zero: retire it but never strobe the register file.
        cwe_q    <= we_q[ptr_q] && (addr_q[ptr_q] != 5'd0);
        caddr_q  <= addr_q[ptr_q];
        cdata_q  <= data_q[ptr_q];
      end else begin
        cvalid_q <= 1'b0;
        cwe_q    <= 1'b0;
      end
    end
  end

  // Entry payload needs no reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (acc0) begin
        we_q[bus.way0_pID_i]   <= bus.way0_rdWriteEnable_i && bus.way0_valid_i;
        addr_q[bus.way0_pID_i] <= bus.way0_rdAddr_i;
        data_q[bus.way0_pID_i] <= bus.way0_rdData_i;
      end
      if (acc1) begin
        we_q[bus.way1_pID_i]   <= bus.way1_rdWriteEnable_i && bus.way1_valid_i;
        addr_q[bus.way1_pID_i] <= bus.way1_rdAddr_i;
        data_q[bus.way1_pID_i] <= bus.way1_rdData_i;
      end
    end
  end

  assign bus.way0_ready_o    = ready0;
  assign bus.way1_ready_o    = ready1;
  assign bus.rdWriteEnable_o = cwe_q;
  assign bus.rdAddr_o        = caddr_q;
  assign bus.rdData_o        = cdata_q;
  assign bus.commitValid_o   = cvalid_q;
  assign bus.commitPID_o     = cpid_q;
  assign bus.occupancy_o     = occ_cnt;

endmodule
